// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Round-robin arbiter/sequencer sharing one signed multiplier among NREQ
//   requesters. One operand pair is accepted at a time, held on the
//   multiplier pins for MULT_LAT cycles with mult_en high, and the product is
//   returned on a single tagged response channel with backpressure.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b      packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready  product handshake
//   resp_data, resp_id  2*WIDTH product and owning requester index
//   busy              high whenever an operation is in progress
//   mult_a/b, mult_en to the shared multiplier
//   mult_out          from the shared multiplier
module mult_share_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [2*WIDTH-1:0]        resp_data,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic                      busy,
  output logic [WIDTH-1:0]          mult_a,
  output logic [WIDTH-1:0]          mult_b,
  output logic                      mult_en,
  input  logic [2*WIDTH-1:0]        mult_out
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic             found;
  logic [CW-1:0]    cnt;
  logic             cnt_last;

  assign cnt_last = (cnt == CW'(MULT_LAT - 1));

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    logic [IDW-1:0] idx;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + int'(k)) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // req_ready is combinational from req_valid; forced low while rst is held
  // so that nothing looks accepted during reset.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && found && !rst) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (found)                   state_nxt = S_WAIT;
      S_WAIT: if (cnt_last)                state_nxt = S_RESP;
      S_RESP: if (resp_ready)              state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  assign mult_en    = (state == S_WAIT);
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
      resp_id   <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (found) begin
            mult_a  <= req_a[grant*WIDTH +: WIDTH];
            mult_b  <= req_b[grant*WIDTH +: WIDTH];
            resp_id <= grant;
            rr_ptr  <= IDW'((int'(grant) + 1) % NREQ);
            cnt     <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (cnt_last) begin
            resp_data <= mult_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Drives mult_share_arbiter with directed and random traffic. A timestamped
//   transaction model (grant by rotating priority, response due MULT_LAT+1
//   cycles after the handshake, product by plain arithmetic) supplies every
//   expected value. A behavioural pipelined multiplier feeds mult_out and
//   outputs junk whenever mult_en was low, so mistimed captures show up.
module tb_mult_share_arbiter;

  localparam int W    = 32;
  localparam int N    = 4;
  localparam int L    = 2;
  localparam int IDW  = $clog2(N);
  localparam int PIDX = (L > 1) ? L - 2 : 0;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N*W-1:0]       req_a = '0;
  logic [N*W-1:0]       req_b = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [2*W-1:0]       resp_data;
  logic [IDW-1:0]       resp_id;
  logic                 busy;
  logic [W-1:0]         mult_a;
  logic [W-1:0]         mult_b;
  logic                 mult_en;
  logic [2*W-1:0]       mult_out;

  mult_share_arbiter #(.WIDTH(W), .NREQ(N), .MULT_LAT(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_en    (mult_en),
    .mult_out   (mult_out)
  );

  always #5 clk = ~clk;

  function automatic longint smul(input logic [W-1:0] a, input logic [W-1:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  // Shared multiplier stand-in: product appears L cycles after operands
  // are presented with mult_en high; otherwise random junk flows through.
  logic [2*W-1:0] pipe [L];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= mult_en ? 64'(smul(mult_a, mult_b)) : {$urandom, $urandom};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mult_out = (L == 1) ? 64'(smul(mult_a, mult_b)) : pipe[PIDX];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction model
  bit           m_active = 1'b0;
  int           m_id     = 0;
  logic [W-1:0] m_a, m_b;
  int           m_resp_at = 0;
  int           m_rr      = 0;
  int           cyc       = 0;
  bit [N-1:0]   sticky    = '0;

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  // One clock cycle: compare at negedge, advance model at posedge.
  task automatic cycle();
    int           g;
    logic [N-1:0] exp_rdy;
    bit           wait_ph, resp_ph;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    if (!m_active) begin
      g = model_grant();
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    wait_ph = m_active && (cyc < m_resp_at);
    resp_ph = m_active && (cyc >= m_resp_at);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(m_active));
    check("mult_en", 64'(mult_en), 64'(wait_ph));
    check("resp_valid", 64'(resp_valid), 64'(resp_ph));
    if (wait_ph) begin
      check("mult_a", 64'(mult_a), 64'(m_a));
      check("mult_b", 64'(mult_b), 64'(m_b));
    end
    if (resp_ph) begin
      check("resp_data", resp_data, 64'(smul(m_a, m_b)));
      check("resp_id", 64'(resp_id), 64'(m_id));
    end
    @(posedge clk);
    if (!m_active) begin
      if (g >= 0) begin
        m_active  = 1'b1;
        m_id      = g;
        m_a       = req_a[g*W +: W];
        m_b       = req_b[g*W +: W];
        m_resp_at = cyc + L + 1;
        m_rr      = (g + 1) % N;
      end
    end else if (resp_ph && resp_ready) begin
      m_active = 1'b0;
    end
    cyc++;
    #1;
    if (g >= 0 && !sticky[g]) req_valid[g] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((req_valid != '0 || m_active) && n < budget) begin
      cycle();
      n++;
    end
    if (req_valid != '0 || m_active) check("drain_timeout", 64'(1), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_resp_data"}, resp_data, 64'(0));
    check({tag, "_resp_id"}, 64'(resp_id), 64'(0));
    check({tag, "_mult_a"}, 64'(mult_a), 64'(0));
    check({tag, "_mult_b"}, 64'(mult_b), 64'(0));
    check({tag, "_mult_en"}, 64'(mult_en), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    req_valid = '0;
    sticky    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_active = 1'b0;
    m_rr     = 0;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom % 8)
      0:       return 32'h8000_0000;
      1:       return 32'h7fff_ffff;
      2:       return 32'hffff_ffff;
      3:       return 32'(0);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    #2;
    do_reset("rst0");

    // Single request
    resp_ready = 1'b1;
    set_req(0, 32'(12), -32'sd32);
    drain(20);

    // Round robin from reset
    do_reset("rst1");
    set_req(0, 32'(5), 32'(15));
    set_req(1, -32'sd51, -32'sd4);
    set_req(2, -32'sd25, -32'sd60);
    set_req(3, 32'(0), 32'(1234));
    drain(40);

    // Fairness between two continuous requesters
    sticky = 4'b1010;
    set_req(1, 32'(3), 32'(7));
    set_req(3, -32'sd9, 32'(11));
    repeat (6 * (L + 2)) cycle();
    sticky    = '0;
    req_valid = '0;
    drain(20);

    // Backpressure
    resp_ready = 1'b0;
    set_req(2, 32'hffff_ffff, 32'hffff_ffff);
    repeat (L + 1 + 10) cycle();
    resp_ready = 1'b1;
    drain(20);

    // Extremes
    set_req(1, 32'h8000_0000, 32'h8000_0000);
    drain(20);
    set_req(0, -32'sd12, 32'(72));
    drain(20);
    set_req(3, 32'(13), 32'(20));
    drain(20);

    // Reset in the middle of WAIT
    set_req(2, 32'(1), 32'(12));
    n = 0;
    while (!m_active && n < 10) begin
      cycle();
      n++;
    end
    if (!m_active) check("grant_timeout", 64'(1), 64'(0));
    do_reset("rst_mid");
    set_req(1, 32'(1), 32'(12));
    set_req(3, 32'(7), 32'(7));
    drain(40);
    set_req(0, 32'(1), 32'(12));
    drain(20);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom % 3 == 0) set_req(i, rand_operand(), rand_operand());
        end else if ($urandom % 16 == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom % 4) != 0;
      cycle();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
